// File: rtl/spram_banked_if.sv
// Request/response bundle for spram_banked; master drives requests, slave returns acks and data.
interface spram_banked_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15,
  parameter int BANK_BITS  = 1
);
  localparam int NBANKS = 1 << BANK_BITS;

  logic                    sel_i;
  logic                    wr_en_i;
  logic [DATA_WIDTH/8-1:0] wr_mask_i;
  logic [ADDR_WIDTH-1:0]   address_in_i;
  logic [DATA_WIDTH-1:0]   data_in_i;
  logic [DATA_WIDTH-1:0]   data_out_o;
  logic                    ack_o;
  logic                    ready_o;
  logic [NBANKS-1:0]       sleep_o;

  modport master (
    output sel_i, wr_en_i, wr_mask_i, address_in_i, data_in_i,
    input  data_out_o, ack_o, ready_o, sleep_o
  );

  modport slave (
    input  sel_i, wr_en_i, wr_mask_i, address_in_i, data_in_i,
    output data_out_o, ack_o, ready_o, sleep_o
  );
endinterface

// File: rtl/spram_banked.sv
// Banked single-port RAM: in-order ack READ_LATENCY cycles after acceptance; ready_o drops only while a
// sleeping bank wakes (per-bank power management under SPRAM_SLEEP_EN, otherwise ready_o is tied high).
module spram_banked #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 15,
  parameter int BANK_BITS    = 1,
  parameter int READ_LATENCY = 1,
  parameter int IDLE_CYCLES  = 16,
  parameter int WAKE_CYCLES  = 2
) (
  input  logic          clk,
  input  logic          reset_i,
  spram_banked_if.slave bus
);
  localparam int NBANKS = 1 << BANK_BITS;
  localparam int OFF_W  = ADDR_WIDTH - BANK_BITS;
  localparam int NBYTES = DATA_WIDTH / 8;

  if ((DATA_WIDTH % 8) != 0 || READ_LATENCY < 1 || READ_LATENCY > 4 ||
      BANK_BITS < 1 || BANK_BITS >= ADDR_WIDTH || IDLE_CYCLES < 1 || WAKE_CYCLES < 0) begin : g_bad_cfg
    $error("spram_banked: illegal parameter combination");
  end

  logic                  w_accept;
  logic [BANK_BITS-1:0]  w_bank;
  logic [OFF_W-1:0]      w_off;
  logic [NBANKS-1:0]     w_hit;
  logic [DATA_WIDTH-1:0] w_bank_rd [NBANKS];
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_bank   = bus.address_in_i[ADDR_WIDTH-1 -: BANK_BITS];
  assign w_off    = bus.address_in_i[OFF_W-1:0];
  // No acceptance while in reset, so a write can never land half-way through a reset pulse.
  assign w_accept = bus.sel_i & bus.ready_o & ~reset_i;
  assign w_rdata  = w_bank_rd[w_bank];

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] r_mem [0:(1 << OFF_W)-1];

    assign w_hit[b] = w_accept && (w_bank == BANK_BITS'(b));

    always_ff @(posedge clk) begin
      if (w_hit[b] && bus.wr_en_i) begin
        for (int k = 0; k < NBYTES; k++) begin
          if (bus.wr_mask_i[k]) r_mem[w_off][8*k +: 8] <= bus.data_in_i[8*k +: 8];
        end
      end
    end

    assign w_bank_rd[b] = w_hit[b] ? r_mem[w_off] : '0;
  end

  // Last-stage inputs: the data register loads on the same edge the ack rises.
  logic                  w_last_vld;
  logic                  w_last_rd;
  logic [DATA_WIDTH-1:0] w_last_dat;

  if (READ_LATENCY == 1) begin : g_lat1
    assign w_last_vld = w_accept;
    assign w_last_rd  = ~bus.wr_en_i;
    assign w_last_dat = w_rdata;
  end else begin : g_latn
    localparam int D = READ_LATENCY - 1;
    logic [D-1:0]          r_vld;
    logic [D-1:0]          r_rd;
    logic [DATA_WIDTH-1:0] r_dat [D];

    always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
        r_vld <= '0;
        r_rd  <= '0;
        for (int i = 0; i < D; i++) r_dat[i] <= '0;
      end else begin
        r_vld[0] <= w_accept;
        r_rd[0]  <= ~bus.wr_en_i;
        r_dat[0] <= w_rdata;
        for (int i = 1; i < D; i++) begin
          r_vld[i] <= r_vld[i-1];
          r_rd[i]  <= r_rd[i-1];
          r_dat[i] <= r_dat[i-1];
        end
      end
    end

    assign w_last_vld = r_vld[D-1];
    assign w_last_rd  = r_rd[D-1];
    assign w_last_dat = r_dat[D-1];
  end

  logic                  r_ack;
  logic [DATA_WIDTH-1:0] r_dout;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_ack  <= 1'b0;
      r_dout <= '0;
    end else begin
      r_ack <= w_last_vld;
      if (w_last_vld && w_last_rd) r_dout <= w_last_dat;
    end
  end

  assign bus.ack_o      = r_ack;
  assign bus.data_out_o = r_dout;

`ifdef SPRAM_SLEEP_EN
  typedef enum logic [1:0] {ST_ACTIVE, ST_SLEEP, ST_WAKE} bank_st_t;

  localparam int CW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES + 1) : 1;
  localparam int WW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES + 1) : 1;

  logic [NBANKS-1:0] w_req_hit;
  logic [NBANKS-1:0] w_active;
  logic [NBANKS-1:0] w_sleep;

  for (genvar b = 0; b < NBANKS; b++) begin : g_pm
    bank_st_t        r_st;
    logic [CW-1:0]   r_idle;
    logic [WW-1:0]   r_wake;
    logic            r_sleep;

    assign w_req_hit[b] = bus.sel_i && (w_bank == BANK_BITS'(b));
    assign w_active[b]  = (r_st == ST_ACTIVE);
    assign w_sleep[b]   = r_sleep;

    // The cycle that first sees the request counts as the first wake cycle.
    always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
        r_st    <= ST_ACTIVE;
        r_idle  <= '0;
        r_wake  <= '0;
        r_sleep <= 1'b0;
      end else begin
        case (r_st)
          ST_ACTIVE: begin
            if (w_hit[b]) begin
              r_idle <= '0;
            end else if (r_idle == CW'(IDLE_CYCLES - 1)) begin
              r_idle  <= CW'(IDLE_CYCLES);
              r_st    <= ST_SLEEP;
              r_sleep <= 1'b1;
            end else if (r_idle < CW'(IDLE_CYCLES)) begin
              r_idle <= r_idle + 1'b1;
            end
          end
          ST_SLEEP: begin
            if (w_req_hit[b]) begin
              if (WAKE_CYCLES <= 1) begin
                r_st    <= ST_ACTIVE;
                r_sleep <= 1'b0;
                r_idle  <= '0;
              end else begin
                r_st   <= ST_WAKE;
                r_wake <= WW'(WAKE_CYCLES - 1);
              end
            end
          end
          ST_WAKE: begin
            if (r_wake <= WW'(1)) begin
              r_st    <= ST_ACTIVE;
              r_sleep <= 1'b0;
              r_idle  <= '0;
            end else begin
              r_wake <= r_wake - 1'b1;
            end
          end
          default: begin
            r_st    <= ST_ACTIVE;
            r_sleep <= 1'b0;
            r_idle  <= '0;
          end
        endcase
      end
    end
  end

  assign bus.ready_o = ~|(w_req_hit & ~w_active);
  assign bus.sleep_o = w_sleep;
`else
  assign bus.ready_o = 1'b1;
  assign bus.sleep_o = '0;
`endif
endmodule

// File: tb/tb_spram_banked.sv
// Bench for spram_banked: a READ_LATENCY=1 and a READ_LATENCY=3 instance against a word-array model.
module tb_spram_banked;
  logic        clk = 1'b0;
  logic        reset_i;
  logic        sel, tgt, wr_en;
  logic [3:0]  mask;
  logic [14:0] addr;
  logic [31:0] din;

  always #5 clk = ~clk;

  spram_banked_if bus1 ();
  spram_banked_if bus3 ();

  assign bus1.sel_i        = sel & ~tgt;
  assign bus3.sel_i        = sel & tgt;
  assign bus1.wr_en_i      = wr_en;
  assign bus3.wr_en_i      = wr_en;
  assign bus1.wr_mask_i    = mask;
  assign bus3.wr_mask_i    = mask;
  assign bus1.address_in_i = addr;
  assign bus3.address_in_i = addr;
  assign bus1.data_in_i    = din;
  assign bus3.data_in_i    = din;

  spram_banked #(.READ_LATENCY(1)) dut1 (.clk(clk), .reset_i(reset_i), .bus(bus1));
  spram_banked #(.READ_LATENCY(3)) dut3 (.clk(clk), .reset_i(reset_i), .bus(bus3));

  logic        acks   [2];
  logic        readys [2];
  logic [31:0] douts  [2];
  logic [1:0]  sleeps [2];
  assign acks[0]   = bus1.ack_o;      assign acks[1]   = bus3.ack_o;
  assign readys[0] = bus1.ready_o;    assign readys[1] = bus3.ready_o;
  assign douts[0]  = bus1.data_out_o; assign douts[1]  = bus3.data_out_o;
  assign sleeps[0] = bus1.sleep_o;    assign sleeps[1] = bus3.sleep_o;

  typedef struct {
    int          dut;
    int          due;
    bit          rd;
    logic [31:0] dat;
  } exp_t;

  exp_t        expq [$];
  logic [31:0] mdl  [2][0:32767];
  logic [31:0] last [2];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Ack is due on the cycle index lat-1 after the accepting edge; data_out holds the last read.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit eack;
      eack = 1'b0;
      if (reset_i) begin
        last[d] = '0;
      end else begin
        for (int i = 0; i < expq.size(); i++) begin
          if (expq[i].dut == d && expq[i].due == cyc) begin
            eack = 1'b1;
            if (expq[i].rd) last[d] = expq[i].dat;
          end
        end
      end
      chk(d == 0 ? "ack_lat1" : "ack_lat3", 64'(acks[d]), 64'(eack));
      chk(d == 0 ? "dout_lat1" : "dout_lat3", 64'(douts[d]), 64'(last[d]));
`ifndef SPRAM_SLEEP_EN
      chk("ready_const", 64'(readys[d]), 64'd1);
      chk("sleep_const", 64'(sleeps[d]), 64'd0);
`endif
    end
    if (reset_i) expq.delete();
    else for (int i = expq.size() - 1; i >= 0; i--) if (expq[i].due <= cyc) expq.delete(i);
  end

  // Called #1 after a posedge; returns #1 after the accepting posedge with sel dropped.
  task automatic req(input int t, input bit we, input logic [3:0] m, input logic [14:0] a,
                     input logic [31:0] d);
    bit   done;
    int   n;
    exp_t e;
    done = 1'b0;
    n    = 0;
    tgt = (t != 0); wr_en = we; mask = m; addr = a; din = d; sel = 1'b1;
    while (!done && n < 20) begin
      @(negedge clk);
      if (readys[t]) begin
        done  = 1'b1;
        e.dut = t;
        e.due = cyc + (t == 0 ? 1 : 3);
        e.rd  = !we;
        if (we) for (int k = 0; k < 4; k++) if (m[k]) mdl[t][a][8*k +: 8] = d[8*k +: 8];
        e.dat = mdl[t][a];
        expq.push_back(e);
      end
      @(posedge clk);
      #1;
      n++;
    end
    sel = 1'b0;
    if (!done) chk("req_accept_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    sel = 0; tgt = 0; wr_en = 0; mask = 0; addr = 0; din = 0; reset_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 64'(bus1.ack_o), 64'd0);
    chk("rst_dout", 64'(bus1.data_out_o), 64'd0);
    chk("rst_ready", 64'(bus1.ready_o), 64'd1);
    chk("rst_sleep", 64'(bus1.sleep_o), 64'd0);
    @(negedge clk); #2 reset_i = 1'b0;
    @(posedge clk); #1;

    req(0, 1, 4'hF, 15'h0010, 32'hDEADBEEF);
    chk("wr_ack_1cyc", 64'(bus1.ack_o), 64'd1);
    req(0, 0, 4'h0, 15'h0010, 32'h0);
    chk("rd_ack_1cyc", 64'(bus1.ack_o), 64'd1);
    chk("rd_deadbeef", 64'(bus1.data_out_o), 64'hDEADBEEF);

    req(0, 1, 4'h0, 15'h0010, 32'h12345678);
    chk("mask0_wr_keeps_dout", 64'(bus1.data_out_o), 64'hDEADBEEF);
    req(0, 0, 4'h0, 15'h0010, 32'h0);
    chk("mask0_unchanged", 64'(bus1.data_out_o), 64'hDEADBEEF);

    req(0, 1, 4'hF, 15'h4000, 32'hFFFFFFFF);
    req(0, 1, 4'b0101, 15'h4000, 32'h11223344);
    req(0, 0, 4'h0, 15'h4000, 32'h0);
    chk("byte_mask_merge", 64'(bus1.data_out_o), 64'hFF22FF44);

    req(0, 1, 4'hF, 15'h3FFF, 32'hA5A50F0F);
    req(0, 1, 4'hF, 15'h7FFF, 32'h5A5AF0F0);
    req(0, 0, 4'h0, 15'h3FFF, 32'h0);
    chk("bank0_top", 64'(bus1.data_out_o), 64'hA5A50F0F);
    req(0, 0, 4'h0, 15'h7FFF, 32'h0);
    chk("bank1_top", 64'(bus1.data_out_o), 64'h5A5AF0F0);

    req(1, 1, 4'hF, 15'h0001, 32'h11110001);
    req(1, 1, 4'hF, 15'h0002, 32'h22220002);
    req(1, 1, 4'hF, 15'h0003, 32'h33330003);
    repeat (3) @(posedge clk);
    #1;
    req(1, 0, 4'h0, 15'h0001, 32'h0);
    req(1, 0, 4'h0, 15'h0002, 32'h0);
    req(1, 0, 4'h0, 15'h0003, 32'h0);
    chk("lat3_ack0", 64'(bus3.ack_o), 64'd1);
    chk("lat3_dat0", 64'(bus3.data_out_o), 64'h11110001);
    @(posedge clk); #1;
    chk("lat3_ack1", 64'(bus3.ack_o), 64'd1);
    chk("lat3_dat1", 64'(bus3.data_out_o), 64'h22220002);
    @(posedge clk); #1;
    chk("lat3_ack2", 64'(bus3.ack_o), 64'd1);
    chk("lat3_dat2", 64'(bus3.data_out_o), 64'h33330003);
    @(posedge clk); #1;
    chk("lat3_idle", 64'(bus3.ack_o), 64'd0);
    chk("lat3_hold", 64'(bus3.data_out_o), 64'h33330003);

    req(1, 0, 4'h0, 15'h0001, 32'h0);
    req(1, 0, 4'h0, 15'h0002, 32'h0);
    reset_i = 1'b1;
    #1;
    chk("inflight_rst_ack", 64'(bus3.ack_o), 64'd0);
    chk("inflight_rst_dout", 64'(bus3.data_out_o), 64'd0);
    chk("inflight_rst_ready", 64'(bus3.ready_o), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk); #2 reset_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    req(0, 0, 4'h0, 15'h0010, 32'h0);
    chk("retained_after_rst", 64'(bus1.data_out_o), 64'hDEADBEEF);
    req(1, 0, 4'h0, 15'h0002, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("retained_lat3", 64'(bus3.data_out_o), 64'h22220002);

    repeat (20) @(posedge clk);
    #1;
`ifdef SPRAM_SLEEP_EN
    chk("all_asleep", 64'(bus1.sleep_o), 64'd3);
    tgt = 1'b0; wr_en = 1'b0; mask = 4'h0; addr = 15'h4000; sel = 1'b1;
    #1;
    chk("wake_ready_drop", 64'(bus1.ready_o), 64'd0);
    @(posedge clk); #1;
    chk("wake_ready_hold", 64'(bus1.ready_o), 64'd0);
    @(posedge clk); #1;
    chk("wake_ready_back", 64'(bus1.ready_o), 64'd1);
    req(0, 0, 4'h0, 15'h4000, 32'h0);
    chk("wake_ack", 64'(bus1.ack_o), 64'd1);
    chk("wake_retained", 64'(bus1.data_out_o), 64'hFF22FF44);
    chk("wake_sleep_vec", 64'(bus1.sleep_o), 64'd1);
`else
    tgt = 1'b0; wr_en = 1'b0; mask = 4'h0; addr = 15'h4000; sel = 1'b1;
    #1;
    chk("idle_ready_high", 64'(bus1.ready_o), 64'd1);
    chk("idle_no_sleep", 64'(bus1.sleep_o), 64'd0);
    sel = 1'b0;
`endif
    repeat (5) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/spram_banked.md
SPRAM_BANKED -- requirements
Module: spram_banked

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 15, word address width; depth = 2^ADDR_WIDTH words.
REQ-003 SHALL have parameter BANK_BITS, default 1, bank select width; NBANKS = 2^BANK_BITS; bank index = address_in_i[ADDR_WIDTH-1 -: BANK_BITS].
REQ-004 SHALL have parameter READ_LATENCY, default 1, range 1..4, cycles from acceptance to ack_o.
REQ-005 SHALL have parameters IDLE_CYCLES, default 16, and WAKE_CYCLES, default 2; both used only under SPRAM_SLEEP_EN.
REQ-006 Ports: clk input 1 clock; single clock domain; all logic on posedge clk.
REQ-007 Ports: reset_i input 1 reset; asynchronous, active-high.
REQ-008 Ports: sel_i input 1 request valid.
REQ-009 Ports: wr_en_i input 1 1=write, 0=read.
REQ-010 Ports: wr_mask_i input DATA_WIDTH/8 byte write enables.
REQ-011 Ports: address_in_i input ADDR_WIDTH word address.
REQ-012 Ports: data_in_i input DATA_WIDTH write data.
REQ-013 Ports: data_out_o output DATA_WIDTH read data, registered.
REQ-014 Ports: ack_o output 1 one-cycle completion pulse.
REQ-015 Ports: ready_o output 1 request acceptance allowed this cycle.
REQ-016 Ports: sleep_o output NBANKS per-bank sleep status.

Function
REQ-017 Request SHALL be accepted on a posedge where sel_i=1 and ready_o=1; inputs are sampled only then.
REQ-018 Accepted requests SHALL be pipelined: one per cycle max, ack_o pulses exactly READ_LATENCY cycles after acceptance, in order, for reads and writes.
REQ-019 Write SHALL update only bytes with wr_mask_i[k]=1; wr_mask_i=0 write SHALL still ack and leave memory unchanged.
REQ-020 Read SHALL present the addressed word on data_out_o in the same cycle ack_o=1; data_out_o SHALL hold until the next read ack; write acks SHALL NOT change data_out_o.
REQ-021 Read immediately after write to same address SHALL return the newly written data.
REQ-022 Without SPRAM_SLEEP_EN, ready_o SHALL be constant 1.
REQ-023 Banks not addressed SHALL see no access; memory contents SHALL NOT be cleared by reset.

Reset
REQ-024 While reset_i=1: ack_o=0, data_out_o=0, ready_o=1, sleep_o=0, latency pipeline emptied, idle counters 0, all banks ACTIVE.
REQ-025 Requests in flight at reset assertion SHALL be dropped with no ack; a write accepted before reset SHALL either complete or not, never partially by byte.

Configuration
REQ-026 Macro SPRAM_SLEEP_EN SHALL compile in per-bank power management; absent, sleep logic is removed and sleep_o is constant 0.
REQ-027 With SPRAM_SLEEP_EN, each bank SHALL run FSM ACTIVE -> SLEEP -> WAKE -> ACTIVE.
REQ-028 ACTIVE: idle counter increments per cycle without accepted access to that bank, saturates at IDLE_CYCLES, clears on access; on reaching IDLE_CYCLES bank goes SLEEP, sleep_o[b]=1.
REQ-029 Access on the cycle the counter would reach IDLE_CYCLES SHALL win: counter clears, no sleep.
REQ-030 sel_i=1 to a SLEEP bank SHALL drop ready_o the same cycle (combinational), go WAKE for WAKE_CYCLES cycles with ready_o=0, then ACTIVE, sleep_o[b]=0, ready_o=1; held request accepted then.
REQ-031 Sleeping bank SHALL retain contents; in-flight pipeline acks SHALL complete during another bank's WAKE.

Verification
REQ-032 Write 0xDEADBEEF mask 4'hF addr 0x0010, read 0x0010 -> ack 1 cycle after each, data_out_o=0xDEADBEEF.
REQ-033 Write 0x11223344 mask 4'b0101 over 0xFFFFFFFF at addr 0x4000 -> read returns 0xFF22FF44.
REQ-034 READ_LATENCY=3, back-to-back reads addr 1,2,3 with distinct data -> three consecutive ack pulses starting 3 cycles after first acceptance, data in order.
REQ-035 SPRAM_SLEEP_EN, 16 idle cycles -> sleep_o=2'b11; read bank 1 -> ready_o=0 for 2 cycles, then ack with retained data, sleep_o=2'b01.
REQ-036 Reset asserted with two reads in flight -> no ack, data_out_o=0, ready_o=1 within same cycle.
